// File: rtl/bg1_shift_reducer_if.sv
// Bundle of signals between the BG1 shift reducer, its controller, the
// shift-value ROM and the downstream circular-shift stage.
`ifndef BG1_MAX_TRANSFORMS
`define BG1_MAX_TRANSFORMS 316
`endif

interface bg1_shift_reducer_if #(
    parameter int N_ENTRIES = `BG1_MAX_TRANSFORMS,
    parameter int W         = 9
);
    logic                   start;
    logic [2:0]             ils;
    logic [W-1:0]           zc;
    logic                   rom_rd_en;
    logic [2:0]             rom_ils;
    logic [W*N_ENTRIES-1:0] bg1_out;
    logic                   bg1_valid;
    logic [W-1:0]           shift_out;
    logic [8:0]             shift_idx;
    logic                   shift_valid;
    logic                   shift_last;
    logic                   shift_ready;
    logic                   busy;
    logic                   done;
    logic                   zc_err;

    // Environment side: controller, ROM and downstream consumer.
    modport master (
        output start, ils, zc, bg1_out, bg1_valid, shift_ready,
        input  rom_rd_en, rom_ils, shift_out, shift_idx, shift_valid,
               shift_last, busy, done, zc_err
    );

    // Reducer side.
    modport slave (
        input  start, ils, zc, bg1_out, bg1_valid, shift_ready,
        output rom_rd_en, rom_ils, shift_out, shift_idx, shift_valid,
               shift_last, busy, done, zc_err
    );
endinterface

// File: rtl/bg1_shift_reducer.sv
// Fetches one ILS's BG1 shift vector, reduces each entry modulo Zc in a 9-stage
// compare-subtract pipeline and streams it out. Zc legality check: BG1_SHIFT_ZC_CHECK_EN.
`ifndef BG1_MAX_TRANSFORMS
`define BG1_MAX_TRANSFORMS 316
`endif

module bg1_shift_reducer #(
    parameter int N_ENTRIES = `BG1_MAX_TRANSFORMS,
    parameter int W         = 9
) (
    input logic                clk,
    input logic                reset,
    bg1_shift_reducer_if.slave bus
);
    localparam int         STAGES   = 9;
    localparam logic [8:0] LAST_IDX = 9'(N_ENTRIES - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, DRAIN} state_e;

    state_e       state_q, state_d;
    logic [8:0]   issue_idx_q, issue_idx_d;
    logic [2:0]   ils_q, ils_d;
    logic [W-1:0] zc_q, zc_d;
    logic         done_q, done_d;
    logic         zc_err_q, zc_err_d;
    logic         zc_bad;
    logic         buf_load;
    logic         issue_vld;
    logic         advance;

    logic [W-1:0] buf_q [N_ENTRIES];

    logic [W-1:0] st_r_q    [STAGES];
    logic [W-1:0] st_r_d    [STAGES];
    logic [8:0]   st_idx_q  [STAGES];
    logic [8:0]   st_idx_d  [STAGES];
    logic         st_last_q [STAGES];
    logic         st_last_d [STAGES];
    logic         st_vld_q  [STAGES];
    logic         st_vld_d  [STAGES];

    // One restoring-division step: subtract zc*2^k when it fits, compared at 2W bits
    // so that large shifted divisors never wrap.
    function automatic logic [W-1:0] reduce_step(input logic [W-1:0] r,
                                                 input logic [W-1:0] zc,
                                                 input int           k);
        logic [2*W-1:0] sub;
        sub = {{W{1'b0}}, zc} << k;
        if ({{W{1'b0}}, r} >= sub) begin
            return r - sub[W-1:0];
        end
        return r;
    endfunction

`ifdef BG1_SHIFT_ZC_CHECK_EN
    assign zc_bad = (bus.zc == '0) || (bus.zc > W'(384));
`else
    assign zc_bad = 1'b0;
`endif

    // A beat is held only while the output is valid and not taken.
    assign advance = !(st_vld_q[STAGES-1] && !bus.shift_ready);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        ils_d       = ils_q;
        zc_d        = zc_q;
        done_d      = 1'b0;
        zc_err_d    = 1'b0;
        buf_load    = 1'b0;
        issue_vld   = 1'b0;
        unique case (state_q)
            IDLE: begin
                issue_idx_d = '0;
                if (bus.start) begin
                    if (zc_bad) begin
                        zc_err_d = 1'b1;
                    end else begin
                        ils_d   = bus.ils;
                        zc_d    = bus.zc;
                        state_d = REQ;
                    end
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (bus.bg1_valid) begin
                    buf_load = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                issue_vld = 1'b1;
                if (advance) begin
                    issue_idx_d = issue_idx_q + 9'd1;
                    if (issue_idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (st_vld_q[STAGES-1] && st_last_q[STAGES-1] && bus.shift_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            issue_idx_q <= '0;
            ils_q       <= '0;
            zc_q        <= '0;
            done_q      <= 1'b0;
            zc_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            ils_q       <= ils_d;
            zc_q        <= zc_d;
            done_q      <= done_d;
            zc_err_q    <= zc_err_d;
        end
    end

    // NOTE: the coefficient buffer is cleared on reset so a restarted job never sees stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                buf_q[i] <= '0;
            end
        end else if (buf_load) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                buf_q[i] <= bus.bg1_out[i*W +: W];
            end
        end
    end

    // Stage j subtracts zc*2^(8-j); stage 0 is fed straight from the buffer.
    always_comb begin
        st_r_d[0]    = reduce_step(buf_q[issue_idx_q], zc_q, STAGES - 1);
        st_idx_d[0]  = issue_idx_q;
        st_last_d[0] = (issue_idx_q == LAST_IDX);
        st_vld_d[0]  = issue_vld;
        for (int j = 1; j < STAGES; j++) begin
            st_r_d[j]    = reduce_step(st_r_q[j-1], zc_q, STAGES - 1 - j);
            st_idx_d[j]  = st_idx_q[j-1];
            st_last_d[j] = st_last_q[j-1];
            st_vld_d[j]  = st_vld_q[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < STAGES; j++) begin
                st_r_q[j]    <= '0;
                st_idx_q[j]  <= '0;
                st_last_q[j] <= 1'b0;
                st_vld_q[j]  <= 1'b0;
            end
        end else if (advance) begin
            for (int j = 0; j < STAGES; j++) begin
                st_r_q[j]    <= st_r_d[j];
                st_idx_q[j]  <= st_idx_d[j];
                st_last_q[j] <= st_last_d[j];
                st_vld_q[j]  <= st_vld_d[j];
            end
        end
    end

    assign bus.rom_rd_en   = (state_q == REQ);
    assign bus.rom_ils     = (state_q == IDLE) ? 3'd0 : ils_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.zc_err      = zc_err_q;
    assign bus.shift_out   = st_r_q[STAGES-1];
    assign bus.shift_idx   = st_idx_q[STAGES-1];
    assign bus.shift_last  = st_last_q[STAGES-1];
    assign bus.shift_valid = st_vld_q[STAGES-1];
endmodule

// File: tb/tb_bg1_shift_reducer.sv
// Scoreboard bench for bg1_shift_reducer: a ROM model answers reads, expected
// beats are queued at start and compared as the DUT hands them off.
`ifndef BG1_MAX_TRANSFORMS
`define BG1_MAX_TRANSFORMS 316
`endif

module tb_bg1_shift_reducer;
    localparam int N = `BG1_MAX_TRANSFORMS;
    localparam int W = 9;

    typedef struct {
        int idx;
        int val;
        bit last;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bg1_shift_reducer_if #(.N_ENTRIES(N), .W(W)) bus ();
    bg1_shift_reducer #(.N_ENTRIES(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    n_total    = 0;
    int    n_bad      = 0;
    int    cyc        = 0;
    int    rd_count   = 0;
    int    spur_cnt   = 0;
    int    first_cyc  = 0;
    int    last_cyc   = 0;
    int    start_cyc  = 0;
    bit    rand_ready = 1'b0;
    beat_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rom_val(input int ils, input int i);
        if (ils == 0 && i == 0) return 0;
        if (ils == 0 && i == 1) return 1;
        if (ils == 0 && i == 2) return 383;
        if (ils == 1 && i == 0) return 7;
        if (ils == 1 && i == 1) return 300;
        if (ils == 1 && i == 2) return 511;
        if (ils == 2 && i == 0) return 383;
        return (i * 37 + ils * 101 + 5) % 512;
    endfunction

    function automatic logic [W*N-1:0] rom_vec(input int ils);
        logic [W*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*W +: W] = W'(rom_val(ils, i));
        end
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.shift_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.shift_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ROM model: vector valid one cycle after the read strobe; can also inject a stray valid.
    initial begin
        bit       rd_seen;
        int       spur_done;
        logic [2:0] rd_ils;
        rd_seen   = 1'b0;
        spur_done = 0;
        rd_ils    = '0;
        bus.bg1_valid = 1'b0;
        bus.bg1_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen) begin
                bus.bg1_valid = 1'b1;
                bus.bg1_out   = rom_vec(int'(rd_ils));
            end else if (spur_done != spur_cnt) begin
                spur_done     = spur_cnt;
                bus.bg1_valid = 1'b1;
                bus.bg1_out   = '1;
            end else begin
                bus.bg1_valid = 1'b0;
            end
            rd_seen = bus.rom_rd_en;
            if (rd_seen) begin
                rd_count++;
                rd_ils = bus.rom_ils;
            end
        end
    end

    // Output monitor: scoreboard pops, stall stability and done timing.
    initial begin
        bit          stalled;
        bit          done_expect;
        logic [19:0] held;
        beat_t       e;
        stalled     = 1'b0;
        done_expect = 1'b0;
        held        = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled     = 1'b0;
                done_expect = 1'b0;
            end else begin
                if (done_expect || bus.done) begin
                    check("done_pulse", 32'(bus.done), 32'(done_expect));
                    if (bus.done) check("busy_at_done", 32'(bus.busy), 0);
                end
                done_expect = 1'b0;
                if (stalled) begin
                    check("hold", 32'({bus.shift_out, bus.shift_idx, bus.shift_last, bus.shift_valid}),
                          32'(held));
                end
                if (bus.shift_valid && bus.shift_ready) begin
                    stalled = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("beat_idx", 32'(bus.shift_idx), 32'(e.idx));
                        check("beat_val", 32'(bus.shift_out), 32'(e.val));
                        check("beat_last", 32'(bus.shift_last), 32'(e.last));
                        if (e.idx == 0) first_cyc = cyc;
                        if (e.last) begin
                            last_cyc    = cyc;
                            done_expect = 1'b1;
                        end
                    end
                end else if (bus.shift_valid) begin
                    stalled = 1'b1;
                    held    = {bus.shift_out, bus.shift_idx, bus.shift_last, bus.shift_valid};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic start_job(input int ils_v, input int zc_v, input bit push);
        int v;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.ils   = 3'(ils_v);
        bus.zc    = W'(zc_v);
        start_cyc = cyc;
        if (push) begin
            for (int i = 0; i < N; i++) begin
                v = rom_val(ils_v, i);
                sb_q.push_back('{idx: i, val: (zc_v == 0) ? v : v % zc_v, last: (i == N - 1)});
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic run_job(input int ils_v, input int zc_v, input bit rnd);
        int rd0;
        rand_ready = rnd;
        rd0 = rd_count;
        start_job(ils_v, zc_v, 1'b1);
        wait_done(4000);
        check("sb_empty", 32'(sb_q.size()), 0);
        check("rom_reads", 32'(rd_count - rd0), 1);
        if (!rnd) begin
            check("first_latency", 32'(first_cyc - start_cyc), 12);
            check("contiguous", 32'(last_cyc - first_cyc), 32'(N - 1));
        end
    endtask

    task automatic check_reset_outs();
        check("rst_rom_rd_en", 32'(bus.rom_rd_en), 0);
        check("rst_rom_ils", 32'(bus.rom_ils), 0);
        check("rst_shift_valid", 32'(bus.shift_valid), 0);
        check("rst_shift_last", 32'(bus.shift_last), 0);
        check("rst_shift_out", 32'(bus.shift_out), 0);
        check("rst_shift_idx", 32'(bus.shift_idx), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_zc_err", 32'(bus.zc_err), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int rd0;
        bus.start = 1'b0;
        bus.ils   = '0;
        bus.zc    = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs();
        reset = 1'b0;

        // Full-size lift, then small Zc values under random backpressure and steady flow.
        run_job(0, 384, 1'b0);
        run_job(1, 2, 1'b1);
        run_job(2, 15, 1'b0);
        run_job(7, 97, 1'b1);

        // A second start and a stray ROM valid while streaming must both be ignored.
        rand_ready = 1'b0;
        rd0 = rd_count;
        start_job(3, 100, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("in_stream_busy", 32'(bus.busy), 1);
        bus.start = 1'b1;
        bus.ils   = 3'd6;
        bus.zc    = W'(5);
        spur_cnt++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(4000);
        check("sb_empty_proto", 32'(sb_q.size()), 0);
        check("rom_reads_proto", 32'(rd_count - rd0), 1);

        // Reset during beat 20, then a clean job from index 0.
        rand_ready = 1'b0;
        start_job(4, 200, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.shift_valid && bus.shift_idx == 9'd20) found = 1'b1;
        end
        check("beat20_seen", 32'(found), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outs();
        reset = 1'b0;
        sb_q.delete();
        run_job(5, 50, 1'b0);

`ifdef BG1_SHIFT_ZC_CHECK_EN
        for (int t = 0; t < 2; t++) begin
            rd0 = rd_count;
            start_job(0, (t == 0) ? 0 : 385, 1'b0);
            @(negedge clk);
            check("zc_err_pulse", 32'(bus.zc_err), 1);
            check("zc_err_busy", 32'(bus.busy), 0);
            @(negedge clk);
            check("zc_err_clear", 32'(bus.zc_err), 0);
            repeat (5) @(negedge clk);
            check("zc_err_idle", 32'(bus.busy), 0);
            check("zc_err_no_read", 32'(rd_count - rd0), 0);
        end
`else
        run_job(6, 0, 1'b0);
        check("zc_err_tied", 32'(bus.zc_err), 0);
`endif

        repeat (3) @(negedge clk);
        check("final_idle", 32'(bus.busy), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/bg1_shift_reducer.md
# bg1_shift_reducer

Downstream consumer of the BG1 shift-value ROM. On a start request it fetches one ILS's shift-coefficient vector from the ROM. It reduces each 9-bit coefficient modulo the active lifting size Zc through a 9-stage compare-subtract pipeline. It then streams the reduced shift amounts, one per cycle under valid/ready flow control, to the circular-shift (cyclic permutation) stage of the encoder datapath.

## Interface
- `N_ENTRIES`, default `BG1_MAX_TRANSFORMS`: coefficient vector length.
- `W`, default 9: width of a coefficient, a shift amount and Zc.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `ils` in 3: ILS index; captured with `start`.
- `zc` in W: lifting size; captured with `start`.
- `rom_rd_en` out 1: read strobe to ROM `rd_en1`.
- `rom_ils` out 3: drives ROM `ils_selected`.
- `bg1_out` in W x N_ENTRIES: ROM coefficient vector.
- `bg1_valid` in 1: ROM vector valid.
- `shift_out` out W: reduced shift amount, V mod Zc.
- `shift_idx` out 9: entry index of `shift_out`.
- `shift_valid` out 1: output beat valid.
- `shift_last` out 1: marks the beat with index N_ENTRIES-1.
- `shift_ready` in 1: downstream accepts the beat.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `zc_err` out 1: one-cycle illegal-Zc pulse (see Configuration).

## Operation
- FSM states: IDLE, REQ, WAIT, STREAM, DRAIN.
- IDLE:
  - On `start`, capture `ils` and `zc` and go to REQ.
  - `start` outside IDLE is ignored; no queueing.
- REQ:
  - `rom_rd_en`=1 for exactly one cycle; `rom_ils` holds the captured `ils` from REQ until return to IDLE.
  - Next state is WAIT.
- WAIT:
  - On `bg1_valid`, copy all N_ENTRIES values of `bg1_out` into an internal buffer and go to STREAM.
  - `bg1_valid` in any other state is ignored.
- STREAM:
  - An issue counter 0..N_ENTRIES-1 injects buffer[idx] into the pipeline, one entry per advancing cycle.
  - After index N_ENTRIES-1 is injected, go to DRAIN.
- DRAIN: wait until the beat with `shift_last` is accepted, then pulse `done` and go to IDLE.
- Modulo pipeline, stages k = 8 down to 0:
  - If r >= (zc << k), compare at 18 bits, then r = r - (zc << k).
  - Each stage registers r, idx and last.
  - Output is exact for any V < 512 and zc >= 1.
- Zc = 0 (macro absent): every compare is true and every subtract is 0, so `shift_out` = V.
- Flow control:
  - The whole pipeline, including the issue counter, advances when NOT (`shift_valid` AND NOT `shift_ready`).
  - A stall freezes all stages, and `shift_out`/`shift_idx`/`shift_last` hold stable.
- No bubbles: with `shift_ready` held high, beats are contiguous.

## Timing
- Reset values:
  - FSM = IDLE.
  - `rom_rd_en`, `shift_valid`, `shift_last`, `busy`, `done`, `zc_err` = 0.
  - `shift_out`, `shift_idx`, `rom_ils` = 0.
  - Buffer contents and pipeline valids are cleared.
- `start` at edge t: `rom_rd_en`=1 during cycle t+1. The ROM returns `bg1_valid` at t+2 and the block enters STREAM at t+3.
- Latency: an entry issued in STREAM cycle s appears on `shift_valid` at s+9 when there are no stalls. The first beat arrives 12 cycles after the `start` edge.
- Total length:
  - Exactly N_ENTRIES beats, indices ascending from 0.
  - `done` is asserted the cycle after the `shift_last` handshake.
  - `busy` falls together with the `done` pulse.
- `reset` mid-operation:
  - Takes effect on the next edge from any state.
  - In-flight beats are discarded and no `done` is issued.
- `shift_ready` low with `shift_valid` low does not stall the pipeline.

## Configuration
- `BG1_SHIFT_ZC_CHECK_EN` defined:
  - In IDLE, `start` with `zc`==0 or `zc`>384 pulses `zc_err` for one cycle.
  - The block stays in IDLE: no ROM read and no beats.
- `BG1_SHIFT_ZC_CHECK_EN` undefined:
  - `zc_err` is tied to 0 and every `start` proceeds.
  - Zc = 0 passes coefficients through unchanged.

## Test plan
- Full-size lift: ils=0, zc=384, buffer entries 0, 1, 383 -> `shift_out` 0, 1, 383. N_ENTRIES contiguous beats, `shift_last` on index N_ENTRIES-1, `done` one cycle later.
- Small Zc: ils=1, zc=2, entries 7, 300, 511 -> `shift_out` 1, 0, 1. Also ils=2, zc=15, entry 383 -> 8.
- Backpressure: random `shift_ready` at 50% duty. Every index appears exactly once, in order, and outputs hold stable during stalls.
- Reset mid-stream: assert `reset` during beat 20.
  - Next cycle: all outputs at their reset values and FSM = IDLE.
  - A new `start` then completes normally from index 0.
- Protocol robustness:
  - `start` pulsed during STREAM is ignored, with no second ROM read.
  - A spurious `bg1_valid` during STREAM does not alter the buffer.
- Zc=0:
  - Macro defined: `zc_err` pulse, `rom_rd_en` never asserted, `busy` stays 0.
  - Macro undefined: outputs equal the raw ROM values.
